// File: rtl/sys_cmd_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sys_cmd_master_if                                                          |
// | Request, UART byte and response signals of the command initiator.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface sys_cmd_master_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4
);
  logic                  req_vld;
  logic                  req_rdy;
  logic [1:0]            req_cmd;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W-1:0]     req_opa;
  logic [DATA_W-1:0]     req_opb;
  logic [FUN_W-1:0]      req_fun;
  logic [DATA_W-1:0]     tx_data;
  logic                  tx_vld;
  logic                  tx_rdy;
  logic [DATA_W-1:0]     rx_data;
  logic                  rx_vld;
  logic [2*DATA_W-1:0]   rsp_data;
  logic                  rsp_vld;
  logic                  rsp_err;

  modport master (
    input  req_vld, req_cmd, req_addr, req_wdata, req_opa, req_opb, req_fun,
    input  tx_rdy, rx_data, rx_vld,
    output req_rdy, tx_data, tx_vld, rsp_data, rsp_vld, rsp_err
  );

  modport slave (
    output req_vld, req_cmd, req_addr, req_wdata, req_opa, req_opb, req_fun,
    output tx_rdy, rx_data, rx_vld,
    input  req_rdy, tx_data, tx_vld, rsp_data, rsp_vld, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/sys_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sys_cmd_master                                                             |
// | Serializes one command request into a UART frame and gathers the response. |
// | Optional response watchdog: define CMD_TIMEOUT_EN.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sys_cmd_master #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int FUN_W       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  wire logic        clk,
  input  wire logic        rst,
  sys_cmd_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TX_BYTE = 2'd1,
    S_RX_RSP  = 2'd2,
    S_RSP_OUT = 2'd3
  } state_t;

  localparam logic [1:0] CMD_ALU     = 2'b00;
  localparam logic [1:0] CMD_ALU_NOP = 2'b01;
  localparam logic [1:0] CMD_WR      = 2'b10;

  generate
    if (DATA_W < ADDR_W || DATA_W < FUN_W || DATA_W < 2 || TIMEOUT_CYC < 1) begin : g_cfg_check
      $error("sys_cmd_master: unsupported parameter set");
    end
  endgenerate

  state_t                state_q, state_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     opa_q, opa_d;
  logic [DATA_W-1:0]     opb_q, opb_d;
  logic [FUN_W-1:0]      fun_q, fun_d;
  logic [1:0]            tx_idx_q, tx_idx_d;
  logic                  rx_cnt_q, rx_cnt_d;
  logic                  req_rdy_q, req_rdy_d;
  logic                  tx_vld_q, tx_vld_d;
  logic [DATA_W-1:0]     tx_data_q, tx_data_d;
  logic [2*DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                  rsp_vld_q, rsp_vld_d;

`ifdef CMD_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  rsp_err_q, rsp_err_d;
`endif

  logic [1:0]            nxt_idx;
  logic [1:0]            last_idx;
  logic                  rsp_last;
  logic [DATA_W-1:0]     nxt_byte;

  // Frame geometry of the captured command: final TX index, final RX index
  // and the byte that follows the one currently on tx_data.
  always_comb begin
    nxt_idx  = tx_idx_q + 2'd1;
    last_idx = 2'd1;
    rsp_last = 1'b1;
    nxt_byte = DATA_W'(fun_q);
    case (cmd_q)
      CMD_ALU: begin
        last_idx = 2'd3;
        case (nxt_idx)
          2'd1:    nxt_byte = opa_q;
          2'd2:    nxt_byte = opb_q;
          default: nxt_byte = DATA_W'(fun_q);
        endcase
      end
      CMD_ALU_NOP: begin
        last_idx = 2'd1;
        nxt_byte = DATA_W'(fun_q);
      end
      CMD_WR: begin
        last_idx = 2'd2;
        nxt_byte = (nxt_idx == 2'd1) ? DATA_W'(addr_q) : wdata_q;
      end
      default: begin
        last_idx = 2'd1;
        rsp_last = 1'b0;
        nxt_byte = DATA_W'(addr_q);
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    fun_d      = fun_q;
    tx_idx_d   = tx_idx_q;
    rx_cnt_d   = rx_cnt_q;
    req_rdy_d  = req_rdy_q;
    tx_vld_d   = tx_vld_q;
    tx_data_d  = tx_data_q;
    rsp_data_d = rsp_data_q;
    rsp_vld_d  = 1'b0;
`ifdef CMD_TIMEOUT_EN
    wd_d       = wd_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        req_rdy_d = 1'b1;
        if (bus.req_vld && req_rdy_q) begin
          cmd_d      = bus.req_cmd;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          opa_d      = bus.req_opa;
          opb_d      = bus.req_opb;
          fun_d      = bus.req_fun;
          tx_idx_d   = 2'd0;
          rx_cnt_d   = 1'b0;
          tx_data_d  = DATA_W'(bus.req_cmd);
          tx_vld_d   = 1'b1;
          req_rdy_d  = 1'b0;
          rsp_data_d = '0;
`ifdef CMD_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = S_TX_BYTE;
        end
      end
      S_TX_BYTE: begin
        if (tx_vld_q && bus.tx_rdy) begin
          if (tx_idx_q == last_idx) begin
            tx_vld_d = 1'b0;
            rx_cnt_d = 1'b0;
`ifdef CMD_TIMEOUT_EN
            wd_d     = '0;
`endif
            // A register write has no response bytes to wait for.
            if (cmd_q == CMD_WR) begin
              rsp_vld_d = 1'b1;
              state_d   = S_RSP_OUT;
            end else begin
              state_d   = S_RX_RSP;
            end
          end else begin
            tx_idx_d  = nxt_idx;
            tx_data_d = nxt_byte;
          end
        end
      end
      S_RX_RSP: begin
        if (bus.rx_vld) begin
          if (rx_cnt_q) rsp_data_d[2*DATA_W-1:DATA_W] = bus.rx_data;
          else          rsp_data_d[DATA_W-1:0]        = bus.rx_data;
`ifdef CMD_TIMEOUT_EN
          wd_d = '0;
`endif
          if (rx_cnt_q == rsp_last) begin
            rsp_vld_d = 1'b1;
            state_d   = S_RSP_OUT;
          end else begin
            rx_cnt_d  = 1'b1;
          end
        end
`ifdef CMD_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
          rsp_vld_d = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = S_RSP_OUT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      default: begin
        req_rdy_d = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      fun_q      <= '0;
      tx_idx_q   <= '0;
      rx_cnt_q   <= 1'b0;
      req_rdy_q  <= 1'b0;
      tx_vld_q   <= 1'b0;
      tx_data_q  <= '0;
      rsp_data_q <= '0;
      rsp_vld_q  <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      wd_q       <= '0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      fun_q      <= fun_d;
      tx_idx_q   <= tx_idx_d;
      rx_cnt_q   <= rx_cnt_d;
      req_rdy_q  <= req_rdy_d;
      tx_vld_q   <= tx_vld_d;
      tx_data_q  <= tx_data_d;
      rsp_data_q <= rsp_data_d;
      rsp_vld_q  <= rsp_vld_d;
`ifdef CMD_TIMEOUT_EN
      wd_q       <= wd_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  assign bus.req_rdy  = req_rdy_q;
  assign bus.tx_vld   = tx_vld_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_vld  = rsp_vld_q;
`ifdef CMD_TIMEOUT_EN
  assign bus.rsp_err  = rsp_err_q;
`else
  assign bus.rsp_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sys_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sys_cmd_master                                                          |
// | Directed and random command transactions against a frame-level model.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sys_cmd_master;
  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 4;
  localparam int FUN_W       = 4;
  localparam int TIMEOUT_CYC = 16;
`ifdef CMD_TIMEOUT_EN
  localparam int LONG_GAP    = 10;
`else
  localparam int LONG_GAP    = 40;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sys_cmd_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W)) bus ();

  sys_cmd_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full transaction. rdy_mode: 0 tx_rdy high, 1 random with stray rx,
  // 2 five cycles of backpressure then high. abort_after>0 resets the DUT
  // after that many TX transfers.
  task automatic run_txn(input logic [1:0] cmd, input logic [3:0] addr,
                         input logic [7:0] wdata, input logic [7:0] opa,
                         input logic [7:0] opb, input logic [3:0] fun,
                         input logic [7:0] rx0, input logic [7:0] rx1,
                         input int rdy_mode, input int n_send,
                         input int max_gap, input int abort_after);
    logic [7:0]  exp_tx[$];
    logic [7:0]  rxb[2];
    logic [15:0] exp_rsp;
    int          n_rsp;
    int          idx;
    int          cyc;
    int          w;
    bit          rdy;

    exp_tx = {};
    exp_tx.push_back({6'b0, cmd});
    case (cmd)
      2'b10: begin exp_tx.push_back({4'b0, addr}); exp_tx.push_back(wdata); n_rsp = 0; end
      2'b11: begin exp_tx.push_back({4'b0, addr}); n_rsp = 1; end
      2'b00: begin exp_tx.push_back(opa); exp_tx.push_back(opb); exp_tx.push_back({4'b0, fun}); n_rsp = 2; end
      default: begin exp_tx.push_back({4'b0, fun}); n_rsp = 2; end
    endcase
    rxb[0]  = rx0;
    rxb[1]  = rx1;
    exp_rsp = 16'h0;
    for (int k = 0; k < n_rsp && k < n_send; k++) exp_rsp = exp_rsp | (16'(rxb[k]) << (8 * k));

    w = 0;
    @(negedge clk);
    while (!bus.req_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("req_rdy_wait", bus.req_rdy, 1);
    if (!bus.req_rdy) return;

    bus.req_vld   = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_opa   = opa;
    bus.req_opb   = opb;
    bus.req_fun   = fun;
    bus.tx_rdy    = 1'b0;
    @(negedge clk);
    bus.req_vld   = 1'b0;
    bus.req_cmd   = 2'($urandom);
    bus.req_addr  = 4'($urandom);
    bus.req_wdata = 8'($urandom);
    bus.req_opa   = 8'($urandom);
    bus.req_opb   = 8'($urandom);
    bus.req_fun   = 4'($urandom);

    idx = 0;
    cyc = 0;
    while (idx < exp_tx.size() && cyc < 200) begin
      check("tx_vld", bus.tx_vld, 1);
      check($sformatf("tx_byte%0d", idx), bus.tx_data, exp_tx[idx]);
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 2) != 0);
        default: rdy = (cyc >= 5);
      endcase
      bus.tx_rdy  = rdy;
      bus.rx_vld  = (rdy_mode == 2 && cyc == 2) || (rdy_mode != 0 && $urandom_range(0, 3) == 0);
      bus.rx_data = 8'($urandom);
      if (rdy) idx++;
      cyc++;
      @(negedge clk);
      bus.rx_vld = 1'b0;
      if (abort_after > 0 && idx == abort_after) begin
        rst = 1'b0;
        #1;
        check("rst_tx_vld", bus.tx_vld, 0);
        check("rst_rsp_vld", bus.rsp_vld, 0);
        check("rst_req_rdy", bus.req_rdy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rel_req_rdy", bus.req_rdy, 1);
        return;
      end
    end
    check("tx_frame_len", idx, exp_tx.size());
    if (idx != exp_tx.size()) return;
    bus.tx_rdy = 1'($urandom);

    if (n_rsp == 0) begin
      check("wr_rsp_vld", bus.rsp_vld, 1);
      check("wr_rsp_data", bus.rsp_data, 0);
      check("wr_tx_vld", bus.tx_vld, 0);
    end else begin
      check("rx_tx_vld", bus.tx_vld, 0);
      for (int k = 0; k < n_rsp && k < n_send; k++) begin
        w = $urandom_range(0, max_gap);
        for (int g = 0; g < w; g++) begin
          check("rsp_early", bus.rsp_vld, 0);
          @(negedge clk);
        end
        bus.rx_vld  = 1'b1;
        bus.rx_data = rxb[k];
        @(negedge clk);
        bus.rx_vld  = 1'b0;
        bus.rx_data = 8'($urandom);
        if (k < n_rsp - 1) check("rsp_early", bus.rsp_vld, 0);
      end
      if (n_send >= n_rsp) begin
        check("rsp_vld", bus.rsp_vld, 1);
        check("rsp_data", bus.rsp_data, exp_rsp);
      end
`ifdef CMD_TIMEOUT_EN
      else begin
        w = 1;
        while (!bus.rsp_vld && w < TIMEOUT_CYC + 8) begin
          @(negedge clk);
          w++;
        end
        check("timeout_latency", w, TIMEOUT_CYC + 1);
        check("timeout_rsp_data", bus.rsp_data, exp_rsp);
      end
`endif
    end
    check("rsp_err", bus.rsp_err, (n_send < n_rsp) ? 1 : 0);
    @(negedge clk);
    check("rsp_pulse", bus.rsp_vld, 0);
    check("req_rdy_back", bus.req_rdy, 1);
    check("rsp_hold", bus.rsp_data, exp_rsp);
  endtask

  initial begin
    bus.req_vld   = 1'b0;
    bus.req_cmd   = 2'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_opa   = '0;
    bus.req_opb   = '0;
    bus.req_fun   = '0;
    bus.tx_rdy    = 1'b0;
    bus.rx_data   = '0;
    bus.rx_vld    = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_req_rdy", bus.req_rdy, 0);
    check("reset_tx_vld", bus.tx_vld, 0);
    check("reset_tx_data", bus.tx_data, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_rsp_vld", bus.rsp_vld, 0);
    check("reset_rsp_err", bus.rsp_err, 0);
    rst = 1'b1;
    @(negedge clk);
    check("release_req_rdy", bus.req_rdy, 1);

    run_txn(2'b10, 4'h5, 8'hA3, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 0, 0, 0, 0);
    run_txn(2'b11, 4'hC, 8'h00, 8'h00, 8'h00, 4'h0, 8'h5A, 8'h00, 0, 1, 2, 0);
    run_txn(2'b00, 4'h0, 8'h00, 8'h10, 8'h20, 4'h2, 8'h00, 8'h02, 0, 2, 2, 0);
    run_txn(2'b01, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 8'hE1, 8'h4C, 2, 2, 2, 0);
    run_txn(2'b01, 4'h0, 8'h00, 8'h00, 8'h00, 4'h7, 8'h11, 8'h22, 0, 2, LONG_GAP, 0);
`ifdef CMD_TIMEOUT_EN
    run_txn(2'b00, 4'h0, 8'h00, 8'h33, 8'h44, 4'h1, 8'h7F, 8'h00, 0, 1, 0, 0);
`endif
    run_txn(2'b00, 4'h0, 8'h00, 8'h11, 8'h22, 4'h5, 8'h00, 8'h00, 0, 2, 2, 2);
    run_txn(2'b11, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0, 8'h96, 8'h00, 0, 1, 2, 0);

    repeat (40) begin
      run_txn(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              4'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 1), 2, 3, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no completion expected completion");
    $fatal(1, "simulation time limit reached");
  end
endmodule
`default_nettype wire
